bitwise_logic_unit: RTL and testbench
=====================================

# bitwise_logic_unit

Parametrised, pipelined bitwise logic unit for the SuperSpeedCPU datapath, the successor to the fixed 20-bit bitwise AND. It performs one of eight bitwise operations on two WIDTH-bit operands, registers the result behind a valid/ready handshake with a one-entry skid buffer, and reports a zero flag. An optional accumulator mode feeds the previous result back as operand A. It sits between the register-file read stage and writeback, alongside the adder.

## Interface
- WIDTH, 20, operand and result width (≥1)
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands/op presented
- in_ready  output  1  unit can accept this cycle
- op  input  3  operation select
- i0  input  WIDTH  operand A
- i1  input  WIDTH  operand B
- acc  input  1  use accumulator instead of i0 (see Configuration)
- out_valid  output  1  s/zero hold a result
- out_ready  input  1  downstream accepts
- s  output  WIDTH  result
- zero  output  1  s == 0

## Operation
- Op encodings: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (A & ~B), 111 PASS (A).
- Accept = in_valid & in_ready; the result is computed combinationally from A and i1 and captured on the same edge.
- Storage: output register (OUT) plus skid register (SKID); occupancy 0, 1 or 2.
  - EMPTY: accept -> OUT loaded, go ONE.
  - ONE: accept & out_ready -> OUT replaced, stay ONE. Accept & !out_ready -> SKID loaded, go FULL. Pop without accept -> EMPTY.
  - FULL: pop -> SKID moves to OUT, go ONE. No accept is possible.
- Pop = out_valid & out_ready.
- in_ready = !FULL, driven from a register (state), not from out_ready.
- Results leave in acceptance order; none are dropped or duplicated.
- zero is registered together with each result and travels with it through SKID.
- Accumulator register ACC, WIDTH bits, is loaded with every accepted result at accept time, independent of output stalls. Back-to-back acc ops therefore chain correctly.
- When out_valid=0, s and zero are held at their last value; they are 0 after reset.

## Timing
- Reset (rst_n=0 at an edge): occupancy 0, out_valid=0, s=0, zero=0, ACC=0, in_ready=1 from the first cycle after reset. Reset mid-operation discards OUT and SKID contents.
- Latency: 1 cycle, from the accept edge to out_valid=1 with the result.
- Throughput: 1 result per cycle while out_ready=1.
- Stall:
  - The first stalled accept fills SKID.
  - in_ready falls in the cycle after that edge.
  - in_ready rises in the cycle after the first pop from FULL.
- Simultaneous accept and pop in ONE: OUT takes the new result. There is no bubble and no SKID use.
- out_valid=1 and s remain stable while out_ready=0.

## Configuration
- Macro: BITWISE_LOGIC_ACCUM_EN.
- Defined: acc=1 selects ACC as operand A; the ACC register exists.
- Undefined: the acc port is present but ignored, A is always i0, and no ACC register is built.

## Structure
- Shared header bitwise_logic_defs.vh holds the op encodings (3-bit constants) and the default WIDTH.
- Sub-module bitwise_logic_core (combinational): parameter WIDTH; inputs a, b, op; outputs y and y_zero. The top instantiates it once and contains the skid/handshake FSM and ACC.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, s=0, zero=0 throughout, in_ready=1 after release.
- Basic ops (WIDTH=20): AND 20'hC0003 & 20'hC0003 -> s=20'hC0003, zero=0 one cycle later. AND 20'h0005F & 20'h00000 -> s=0, zero=1. XNOR 20'hFFFFF, 20'hFFFFF -> s=20'hFFFFF. ANDN 20'hFFFFF, 20'h0000F -> s=20'hFFFF0.
- Backpressure: out_ready=0, then offer OR results 1, 2, 3 on consecutive cycles.
  - Expect 1 and 2 accepted, in_ready=0 from the cycle after the second accept, and 3 held.
  - Then raise out_ready -> outputs appear as 1, 2, 3 in order with no loss.
- Streaming: out_ready=1 with 8 back-to-back accepts -> 8 consecutive out_valid cycles, in_ready never drops.
- Accumulator (macro defined): XOR i0=20'hFFFFF, i1=0, acc=0 -> 20'hFFFFF. Then AND acc=1, i1=20'h0F0F0 -> 20'h0F0F0. Then OR acc=1, i1=20'h00001 -> 20'h0F0F1. Repeat with out_ready=0 during the chain -> identical results. With the macro undefined, the same stimulus with i0=0 on the acc=1 steps yields 0 and 1 instead.
- Reset mid-operation: with FULL state and out_ready=0, pulse rst_n=0 for one cycle -> out_valid=0, in_ready=1, ACC=0. The next acc=1 PASS -> s=0.

Source files
------------

// File: rtl/bitwise_logic_unit_pkg.sv
// Shared definitions for the bitwise logic unit: op encodings, default width, FSM states.
// Optional accumulator mode is selected by the BITWISE_LOGIC_ACCUM_EN macro.
package bitwise_logic_unit_pkg;

  localparam int BLU_WIDTH_DEFAULT = 20;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_XOR  = 3'b010,
    OP_NAND = 3'b011,
    OP_NOR  = 3'b100,
    OP_XNOR = 3'b101,
    OP_ANDN = 3'b110,
    OP_PASS = 3'b111
  } blu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } blu_state_e;

endpackage

// File: rtl/bitwise_logic_unit_if.sv
// Handshake bundle for the bitwise logic unit: operand channel in, result channel out.
interface bitwise_logic_unit_if
  import bitwise_logic_unit_pkg::*;
#(
  parameter int WIDTH = BLU_WIDTH_DEFAULT
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             zero;

  modport master (
    output in_valid, op, i0, i1, acc, out_ready,
    input  in_ready, out_valid, s, zero
  );

  modport slave (
    input  in_valid, op, i0, i1, acc, out_ready,
    output in_ready, out_valid, s, zero
  );
endinterface

// File: rtl/bitwise_logic_unit_core.sv
// Combinational bitwise operation on two operands plus a zero flag on the result.
module bitwise_logic_core
  import bitwise_logic_unit_pkg::*;
#(
  parameter int WIDTH = BLU_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             y_zero
);

  always_comb begin
    y = '0;
    case (blu_op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_ANDN: y = a & ~b;
      OP_PASS: y = a;
      default: y = '0;
    endcase
  end

  assign y_zero = ~|y;

endmodule

// File: rtl/bitwise_logic_unit.sv
// Pipelined bitwise logic unit: one result register plus a skid entry behind valid/ready.
// Define BITWISE_LOGIC_ACCUM_EN to build the accumulator that can replace operand A.
module bitwise_logic_unit
  import bitwise_logic_unit_pkg::*;
#(
  parameter int WIDTH = BLU_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitwise_logic_unit_if.slave  bus
);

  // state | meaning
  // EMPTY | no result held, out_valid=0
  // ONE   | OUT holds a result, SKID free
  // FULL  | OUT and SKID both hold results, in_ready=0
  blu_state_e state_q, state_d;

  logic [WIDTH-1:0] out_s_q, skid_s_q;
  logic             out_z_q, skid_z_q;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] core_y;
  logic             core_zero;
  logic             in_ready_w, out_valid_w;
  logic             accept, pop;
  logic             out_load_new, out_load_skid, skid_load;

  assign in_ready_w  = (state_q != ST_FULL);
  assign out_valid_w = (state_q != ST_EMPTY);
  assign accept      = bus.in_valid & in_ready_w;
  assign pop         = out_valid_w & bus.out_ready;

`ifdef BITWISE_LOGIC_ACCUM_EN
  logic [WIDTH-1:0] acc_q;

  // ACC follows every accepted result, regardless of whether the output is stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= core_y;
    end
  end

  assign operand_a = bus.acc ? acc_q : bus.i0;
`else
  logic unused_acc;
  assign unused_acc = bus.acc;
  assign operand_a  = bus.i0;
`endif

  bitwise_logic_core #(.WIDTH(WIDTH)) u_core (
    .a      (operand_a),
    .b      (bus.i1),
    .op     (bus.op),
    .y      (core_y),
    .y_zero (core_zero)
  );

  always_comb begin
    state_d       = state_q;
    out_load_new  = 1'b0;
    out_load_skid = 1'b0;
    skid_load     = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          out_load_new = 1'b1;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && bus.out_ready) begin
          out_load_new = 1'b1;
        end else if (accept) begin
          skid_load = 1'b1;
          state_d   = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          out_load_skid = 1'b1;
          state_d       = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      out_s_q  <= '0;
      out_z_q  <= 1'b0;
      skid_s_q <= '0;
      skid_z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (out_load_new) begin
        out_s_q <= core_y;
        out_z_q <= core_zero;
      end else if (out_load_skid) begin
        out_s_q <= skid_s_q;
        out_z_q <= skid_z_q;
      end
      if (skid_load) begin
        skid_s_q <= core_y;
        skid_z_q <= core_zero;
      end
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.s         = out_s_q;
  assign bus.zero      = out_z_q;

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// Self-checking bench for bitwise_logic_unit: vector table, handshake corner cases, random traffic.
module tb_bitwise_logic_unit;
  localparam int W = 20;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bitwise_logic_unit_if #(.WIDTH(W)) bus();

  bitwise_logic_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] i0;
    logic [W-1:0] i1;
    logic [W-1:0] exp_s;
    logic         exp_z;
  } vec_t;

  int passed = 0;
  int total  = 0;

  // Reference: bounded FIFO of {zero, s} in acceptance order, capacity 2.
  logic [W:0]   mq[$];
  logic [W-1:0] pop_log[$];
  logic [W-1:0] acc_m;
  logic [W-1:0] last_s;
  logic         last_z;
  bit           started;
  bit           accepted;

  function automatic logic [W-1:0] ref_op(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return a & ~b;
      default: return a;
    endcase
  endfunction

  task automatic check_b(string name, logic act, logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_w(string name, logic [W-1:0] act, logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_i(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // One clock: predict, clock, then compare DUT against the model.
  task automatic cycle();
    logic [W-1:0] a, r;
    bit acc_ok, pop_ok;
    if (started) check_b("in_ready", bus.in_ready, mq.size() < 2);
`ifdef BITWISE_LOGIC_ACCUM_EN
    a = bus.acc ? acc_m : bus.i0;
`else
    a = bus.i0;
`endif
    r      = ref_op(bus.op, a, bus.i1);
    acc_ok = rst_n && bus.in_valid && (mq.size() < 2);
    pop_ok = rst_n && (mq.size() > 0) && bus.out_ready;
    if (pop_ok) pop_log.push_back(bus.s);
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      acc_m  = '0;
      last_s = '0;
      last_z = 1'b0;
    end else begin
      if (pop_ok) begin
        last_s = mq[0][W-1:0];
        last_z = mq[0][W];
        void'(mq.pop_front());
      end
      if (acc_ok) begin
        mq.push_back({(r == '0), r});
        acc_m = r;
      end
    end
    accepted = acc_ok;
    started  = 1'b1;
    #1;
    check_b("out_valid", bus.out_valid, mq.size() > 0);
    check_w("s", bus.s, (mq.size() > 0) ? mq[0][W-1:0] : last_s);
    check_b("zero", bus.zero, (mq.size() > 0) ? mq[0][W] : last_z);
  endtask

  task automatic send(logic [2:0] op, logic [W-1:0] i0, logic [W-1:0] i1, logic acc);
    bit done = 0;
    bus.op = op; bus.i0 = i0; bus.i1 = i1; bus.acc = acc;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (accepted) begin
        done = 1;
        break;
      end
      if (t >= 2) bus.out_ready = 1'b1;
    end
    if (!done) check_b("send_timeout", 1'b0, 1'b1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 10 && mq.size() > 0; t++) cycle();
    if (mq.size() != 0) check_i("drain_timeout", mq.size(), 0);
  endtask

  vec_t vecs[7];
  logic [W-1:0] exp_acc[3];

  initial begin
    int vcnt, lowcnt;
    bus.in_valid = 1'b1; bus.op = 3'd0; bus.i0 = '0; bus.i1 = '0;
    bus.acc = 1'b0; bus.out_ready = 1'b1;
    rst_n = 1'b0; started = 0; acc_m = '0; last_s = '0; last_z = 1'b0;

    vecs[0] = '{3'b000, 20'hC0003, 20'hC0003, 20'hC0003, 1'b0};
    vecs[1] = '{3'b000, 20'h0005F, 20'h00000, 20'h00000, 1'b1};
    vecs[2] = '{3'b101, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF, 1'b0};
    vecs[3] = '{3'b110, 20'hFFFFF, 20'h0000F, 20'hFFFF0, 1'b0};
    vecs[4] = '{3'b011, 20'hFFFFF, 20'hFFFFF, 20'h00000, 1'b1};
    vecs[5] = '{3'b100, 20'h00000, 20'h00000, 20'hFFFFF, 1'b0};
    vecs[6] = '{3'b111, 20'hAAAAA, 20'h55555, 20'hAAAAA, 1'b0};

    // Reset held two cycles with in_valid asserted
    repeat (2) cycle();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    check_b("reset_in_ready", bus.in_ready, 1'b1);
    check_b("reset_out_valid", bus.out_valid, 1'b0);
    check_w("reset_s", bus.s, '0);

    // Vector table, one cycle latency each
    foreach (vecs[k]) begin
      bus.op = vecs[k].op; bus.i0 = vecs[k].i0; bus.i1 = vecs[k].i1; bus.acc = 1'b0;
      bus.in_valid = 1'b1; bus.out_ready = 1'b1;
      cycle();
      bus.in_valid = 1'b0;
      check_b($sformatf("vec%0d_valid", k), bus.out_valid, 1'b1);
      check_w($sformatf("vec%0d_s", k), bus.s, vecs[k].exp_s);
      check_b($sformatf("vec%0d_zero", k), bus.zero, vecs[k].exp_z);
      drain();
    end

    // Backpressure: 1 and 2 fill OUT and SKID, 3 waits
    pop_log.delete();
    bus.out_ready = 1'b0;
    bus.op = 3'b001; bus.i1 = '0; bus.acc = 1'b0; bus.in_valid = 1'b1;
    bus.i0 = 20'd1; cycle();
    bus.i0 = 20'd2; cycle();
    check_b("bp_in_ready_low", bus.in_ready, 1'b0);
    bus.i0 = 20'd3; cycle();
    check_b("bp_third_held", accepted, 1'b0);
    check_w("bp_stable_s", bus.s, 20'd1);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 10 && !accepted; t++) cycle();
    bus.in_valid = 1'b0;
    drain();
    check_i("bp_count", pop_log.size(), 3);
    for (int k = 0; k < 3 && k < pop_log.size(); k++)
      check_w($sformatf("bp_order%0d", k), pop_log[k], W'(k + 1));

    // Streaming: 8 back-to-back accepts
    vcnt = 0; lowcnt = 0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.op = 3'b010;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) bus.in_valid = 1'b0;
      bus.i0 = W'($urandom); bus.i1 = W'($urandom);
      if (!bus.in_ready) lowcnt++;
      cycle();
      if (bus.out_valid) vcnt++;
    end
    check_i("stream_valid_cycles", vcnt, 8);
    check_i("stream_ready_drops", lowcnt, 0);
    drain();

`ifdef BITWISE_LOGIC_ACCUM_EN
    exp_acc = '{20'hFFFFF, 20'h0F0F0, 20'h0F0F1};
`else
    exp_acc = '{20'hFFFFF, 20'h00000, 20'h00001};
`endif
    // Accumulator chain, free-flowing then stalled
    for (int run = 0; run < 2; run++) begin
      pop_log.delete();
      bus.out_ready = (run == 0);
      send(3'b010, 20'hFFFFF, 20'h00000, 1'b0);
      send(3'b000, 20'h00000, 20'h0F0F0, 1'b1);
      send(3'b001, 20'h00000, 20'h00001, 1'b1);
      drain();
      check_i($sformatf("acc%0d_count", run), pop_log.size(), 3);
      for (int k = 0; k < 3 && k < pop_log.size(); k++)
        check_w($sformatf("acc%0d_res%0d", run, k), pop_log[k], exp_acc[k]);
    end

    // Reset from FULL
    bus.out_ready = 1'b0;
    send(3'b111, 20'h0ABCD, 20'h0, 1'b0);
    send(3'b111, 20'h01234, 20'h0, 1'b0);
    check_b("full_before_reset", bus.in_ready, 1'b0);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    check_b("midrst_out_valid", bus.out_valid, 1'b0);
    check_b("midrst_in_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    send(3'b111, 20'h12345, 20'h0, 1'b1);
`ifdef BITWISE_LOGIC_ACCUM_EN
    check_w("midrst_acc_pass", bus.s, 20'h00000);
`else
    check_w("midrst_acc_pass", bus.s, 20'h12345);
`endif
    drain();

    // Random traffic with occasional resets
    for (int k = 0; k < 400; k++) begin
      rst_n         = ($urandom_range(0, 63) != 0);
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.op        = 3'($urandom);
      bus.i0        = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      bus.i1        = W'($urandom);
      bus.acc       = 1'($urandom);
      cycle();
    end
    rst_n = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
